// File: rtl/or1k_wb_burst_ram.sv
// Wishbone B3 burst-capable RAM slave for the OR1K instruction/data buses.
// Registered ack/err/data, programmable wait states before the first beat of
// every transfer, zero-wait subsequent burst beats, linear and wrap bursts.
module or1k_wb_burst_ram #(
   parameter int          MEM_DEPTH_WIDTH = 10,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int          WAIT_STATES     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic [2:0]  wb_cti_i,
   input  logic [1:0]  wb_bte_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        wb_rty_o
);

   localparam int          AW        = MEM_DEPTH_WIDTH;
   localparam int          DEPTH     = 1 << AW;
   localparam logic [31:0] MEM_BYTES = 32'(DEPTH) << 2;
   localparam logic [2:0]  CTI_INC   = 3'b010;

   typedef enum logic [1:0] {IDLE, WAIT, BURST, ERR} state_t;

   state_t        state, state_n;
   logic [2:0]    wait_cnt, wait_cnt_n;
   logic [AW-1:0] beat_adr, beat_adr_n;
   logic          ack_n, err_n, wr_en;
   logic [31:0]   dat_n;

   logic [31:0]   mem [DEPTH];

   // Request decode: byte offset from the window base, word index inside it.
   logic [31:0]   offset;
   logic          in_range;
   logic [AW-1:0] req_word;
   assign offset   = wb_adr_i - BASE_ADDR;
   assign in_range = offset < MEM_BYTES;
   assign req_word = offset[AW+1:2];

   // Next-beat address: only the bits under the wrap mask advance.
   logic [AW-1:0] inc_adr, wrap_mask, next_adr;
   logic          last_word;
   assign inc_adr   = beat_adr + AW'(1);
   assign next_adr  = (beat_adr & ~wrap_mask) | (inc_adr & wrap_mask);
   assign last_word = (wb_bte_i == 2'b00) && (&beat_adr);

   // Select the wrap boundary from the burst type extension.
   always_comb begin
      case (wb_bte_i)
         2'b01:   wrap_mask = AW'(3);
         2'b10:   wrap_mask = AW'(7);
         2'b11:   wrap_mask = AW'(15);
         default: wrap_mask = '1;
      endcase
   end

   // Next-state and next-output decisions for the bus handshake.
   always_comb begin
      state_n    = state;
      wait_cnt_n = wait_cnt;
      beat_adr_n = beat_adr;
      ack_n      = 1'b0;
      err_n      = 1'b0;
      wr_en      = 1'b0;
      case (state)
         IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               if (!in_range) begin
                  state_n = ERR;
                  err_n   = 1'b1;
               end else begin
                  state_n    = WAIT;
                  wait_cnt_n = 3'(WAIT_STATES);
                  beat_adr_n = req_word;
               end
            end
         end
         WAIT: begin
            if (!wb_cyc_i) begin
               state_n = IDLE;
            end else if (wait_cnt == 3'd0) begin
               state_n = BURST;
               ack_n   = 1'b1;
            end else begin
               wait_cnt_n = wait_cnt - 3'd1;
            end
         end
         BURST: begin
            if (!wb_cyc_i) begin
               state_n = IDLE;
            end else if (wb_ack_o) begin
               // stb low with ack up means the master is stalling: hold the beat
               if (wb_stb_i) begin
                  wr_en = wb_we_i;
                  if (wb_cti_i == CTI_INC) begin
                     if (last_word) begin
                        state_n = ERR;
                        err_n   = 1'b1;
                     end else begin
                        beat_adr_n = next_adr;
                        ack_n      = 1'b1;
                     end
                  end else begin
                     state_n = IDLE;
                  end
               end
            end else if (wb_stb_i) begin
               ack_n = 1'b1;
            end
         end
         ERR: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      dat_n = ack_n ? mem[beat_adr_n] : 32'h0;
   end

   // State and registered bus outputs; reset aborts any transfer in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= 3'd0;
         beat_adr <= '0;
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         wb_dat_o <= 32'h0;
      end else begin
         state    <= state_n;
         wait_cnt <= wait_cnt_n;
         beat_adr <= beat_adr_n;
         wb_ack_o <= ack_n;
         wb_err_o <= err_n;
         wb_dat_o <= dat_n;
      end
   end

   // Byte-lane write of the current beat; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int n = 0; n < 4; n++) begin
            if (wb_sel_i[n]) mem[beat_adr][8*n +: 8] <= wb_dat_i[8*n +: 8];
         end
      end
   end

   assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_or1k_wb_burst_ram.sv
// Randomized bench for or1k_wb_burst_ram with a word-array memory model.
module tb_or1k_wb_burst_ram;

   localparam int          AW    = 10;
   localparam int          DEPTH = 1 << AW;
   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          WS    = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] wb_adr_i = '0;
   logic [31:0] wb_dat_i = '0;
   logic [3:0]  wb_sel_i = '0;
   logic        wb_we_i  = 1'b0;
   logic        wb_cyc_i = 1'b0;
   logic        wb_stb_i = 1'b0;
   logic [2:0]  wb_cti_i = '0;
   logic [1:0]  wb_bte_i = '0;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o, wb_err_o, wb_rty_o;

   int total = 0;
   int bad   = 0;

   logic [31:0] model  [DEPTH];
   logic [31:0] wd_buf [DEPTH];
   logic [31:0] rd_buf [DEPTH];

   always #5 clk = ~clk;

   or1k_wb_burst_ram #(
      .MEM_DEPTH_WIDTH(AW),
      .BASE_ADDR(BASE),
      .WAIT_STATES(WS)
   ) dut (
      .clk(clk), .rst(rst),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
      .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
      .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
      .wb_rty_o(wb_rty_o)
   );

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // Word touched by beat k of a burst starting at word 'start'.
   function automatic int beat_word(input int start, input logic [1:0] bte, input int k);
      int len;
      len = (bte == 2'd1) ? 4 : (bte == 2'd2) ? 8 : (bte == 2'd3) ? 16 : 0;
      if (len == 0) return start + k;
      return (start / len) * len + ((start % len) + k) % len;
   endfunction

   // Bus master: n beats from wd_buf, read data into rd_buf. Optional stall of
   // stall_len cycles when beat stall_k is about to be offered.
   task automatic xfer(input logic we, input logic [31:0] adr, input logic [1:0] bte,
                       input int n, input logic [2:0] cti_last, input logic [3:0] sel,
                       input int stall_k, input int stall_len,
                       output int done, output logic gerr, output int first_lat,
                       output int low_cnt, output logic tail);
      int k, stall_left;
      k = 0; stall_left = stall_len; gerr = 1'b0; first_lat = -1; low_cnt = 0;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr;
      wb_bte_i = bte; wb_sel_i = sel; wb_dat_i = wd_buf[0];
      wb_cti_i = (n == 1) ? cti_last : 3'b010;
      for (int c = 1; c <= n + 40; c++) begin
         @(posedge clk); #1;
         if (wb_err_o) begin gerr = 1'b1; break; end
         if (wb_ack_o && first_lat < 0) first_lat = c;
         if (first_lat >= 0 && !wb_ack_o) low_cnt++;
         if (stall_k >= 0 && k == stall_k && stall_left > 0) begin
            wb_stb_i = 1'b0;
            stall_left--;
         end else begin
            wb_stb_i = 1'b1;
            wb_cti_i = (k == n - 1) ? cti_last : 3'b010;
            wb_dat_i = wd_buf[k];
            if (wb_ack_o) begin
               rd_buf[k] = wb_dat_o;
               k++;
               if (k == n) break;
            end
         end
      end
      done = k;
      @(posedge clk); #1;
      tail = wb_ack_o | wb_err_o;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_cti_i = 3'b000;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      total++; if (wb_ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack got %b want 0", wb_ack_o); end
      total++; if (wb_err_o !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", wb_err_o); end
      total++; if (wb_rty_o !== 1'b0) begin bad++; $display("FAIL reset_rty got %b want 0", wb_rty_o); end
      total++; if (wb_dat_o !== 32'h0) begin bad++; $display("FAIL reset_dat got %h want 0", wb_dat_o); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_fill();
      int done, lat, low; logic gerr, tail;
      for (int w = 0; w < DEPTH; w++) begin wd_buf[w] = $urandom; model[w] = wd_buf[w]; end
      xfer(1'b1, BASE, 2'b00, DEPTH, 3'b111, 4'hF, -1, 0, done, gerr, lat, low, tail);
      total++; if (done !== DEPTH || gerr !== 1'b0) begin bad++; $display("FAIL fill_beats got %0d err %b want %0d", done, gerr, DEPTH); end
      total++; if (low !== 0) begin bad++; $display("FAIL fill_gaps got %0d want 0", low); end
   endtask

   task automatic test_classic_read();
      int done, lat, low; logic gerr, tail;
      wd_buf[0] = 32'hDEADBEEF;
      xfer(1'b1, BASE + 32'h40, 2'b00, 1, 3'b000, 4'hF, -1, 0, done, gerr, lat, low, tail);
      model[16] = 32'hDEADBEEF;
      xfer(1'b0, BASE + 32'h40, 2'b00, 1, 3'b000, 4'hF, -1, 0, done, gerr, lat, low, tail);
      total++; if (done !== 1) begin bad++; $display("FAIL classic_ack got %0d want 1", done); end
      total++; if (lat !== WS + 2) begin bad++; $display("FAIL classic_latency got %0d want %0d", lat, WS + 2); end
      total++; if (rd_buf[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL classic_data got %h want deadbeef", rd_buf[0]); end
      total++; if (tail !== 1'b0) begin bad++; $display("FAIL classic_pulse got %b want 0", tail); end
   endtask

   task automatic test_byte_write();
      int done, lat, low; logic gerr, tail;
      wd_buf[0] = 32'hAABBCCDD;
      xfer(1'b1, BASE + 32'h80, 2'b00, 1, 3'b000, 4'hF, -1, 0, done, gerr, lat, low, tail);
      wd_buf[0] = 32'h11223344;
      xfer(1'b1, BASE + 32'h80, 2'b00, 1, 3'b111, 4'b0101, -1, 0, done, gerr, lat, low, tail);
      model[32] = 32'hAA22CC44;
      xfer(1'b0, BASE + 32'h80, 2'b00, 1, 3'b001, 4'hF, -1, 0, done, gerr, lat, low, tail);
      total++; if (rd_buf[0] !== 32'hAA22CC44) begin bad++; $display("FAIL byte_write got %h want aa22cc44", rd_buf[0]); end
   endtask

   task automatic test_wrap4();
      int done, lat, low; logic gerr, tail;
      logic [31:0] exp;
      for (int i = 0; i < 4; i++) begin
         wd_buf[0] = 32'(i);
         xfer(1'b1, BASE + 32'(4 * i), 2'b00, 1, 3'b000, 4'hF, -1, 0, done, gerr, lat, low, tail);
         model[i] = 32'(i);
      end
      xfer(1'b0, BASE + 32'h08, 2'b01, 4, 3'b111, 4'hF, -1, 0, done, gerr, lat, low, tail);
      total++; if (done !== 4 || low !== 0) begin bad++; $display("FAIL wrap4_beats got %0d gaps %0d want 4 gaps 0", done, low); end
      for (int k = 0; k < 4; k++) begin
         exp = 32'((k + 2) % 4);
         total++; if (rd_buf[k] !== exp) begin bad++; $display("FAIL wrap4_data beat %0d got %h want %h", k, rd_buf[k], exp); end
      end
      total++; if (tail !== 1'b0) begin bad++; $display("FAIL wrap4_end got %b want 0", tail); end
   endtask

   task automatic test_out_of_range();
      int done, lat, low; logic gerr, tail;
      wd_buf[0] = ~model[0];
      xfer(1'b1, BASE + 32'h1000, 2'b00, 1, 3'b000, 4'hF, -1, 0, done, gerr, lat, low, tail);
      total++; if (gerr !== 1'b1 || done !== 0) begin bad++; $display("FAIL oor_err got err %b acks %0d want err 1 acks 0", gerr, done); end
      total++; if (tail !== 1'b0) begin bad++; $display("FAIL oor_err_pulse got %b want 0", tail); end
      xfer(1'b0, BASE, 2'b00, 1, 3'b000, 4'hF, -1, 0, done, gerr, lat, low, tail);
      total++; if (rd_buf[0] !== model[0]) begin bad++; $display("FAIL oor_mem got %h want %h", rd_buf[0], model[0]); end
   endtask

   task automatic test_linear_overflow();
      int done, lat, low; logic gerr, tail;
      for (int k = 0; k < 4; k++) wd_buf[k] = $urandom;
      xfer(1'b1, BASE + 32'((DEPTH - 2) * 4), 2'b00, 4, 3'b111, 4'hF, -1, 0, done, gerr, lat, low, tail);
      model[DEPTH-2] = wd_buf[0];
      model[DEPTH-1] = wd_buf[1];
      total++; if (done !== 2 || gerr !== 1'b1) begin bad++; $display("FAIL overflow got acks %0d err %b want 2 1", done, gerr); end
      total++; if (tail !== 1'b0) begin bad++; $display("FAIL overflow_tail got %b want 0", tail); end
      xfer(1'b0, BASE + 32'((DEPTH - 1) * 4), 2'b00, 1, 3'b000, 4'hF, -1, 0, done, gerr, lat, low, tail);
      total++; if (rd_buf[0] !== model[DEPTH-1]) begin bad++; $display("FAIL overflow_last got %h want %h", rd_buf[0], model[DEPTH-1]); end
      xfer(1'b0, BASE, 2'b00, 1, 3'b000, 4'hF, -1, 0, done, gerr, lat, low, tail);
      total++; if (rd_buf[0] !== model[0]) begin bad++; $display("FAIL overflow_word0 got %h want %h", rd_buf[0], model[0]); end
   endtask

   task automatic test_stall();
      int done, lat, low; logic gerr, tail;
      xfer(1'b0, BASE + 32'(100 * 4), 2'b00, 4, 3'b111, 4'hF, 2, 2, done, gerr, lat, low, tail);
      total++; if (done !== 4) begin bad++; $display("FAIL stall_beats got %0d want 4", done); end
      total++; if (low !== 2) begin bad++; $display("FAIL stall_ack_low got %0d want 2", low); end
      for (int k = 0; k < 4; k++) begin
         total++; if (rd_buf[k] !== model[100 + k]) begin bad++; $display("FAIL stall_data beat %0d got %h want %h", k, rd_buf[k], model[100 + k]); end
      end
   endtask

   task automatic test_reset_mid_burst();
      int done, lat, low, beats; logic gerr, tail, seen;
      logic [31:0] d [3];
      for (int i = 0; i < 3; i++) d[i] = ~model[200 + i];
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = BASE + 32'(200 * 4);
      wb_cti_i = 3'b010; wb_bte_i = 2'b00; wb_sel_i = 4'hF; wb_dat_i = d[0];
      beats = 0; seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (wb_ack_o) begin
            if (beats == 2) begin seen = 1'b1; break; end
            wb_dat_i = d[beats];
            beats++;
         end
      end
      total++; if (seen !== 1'b1) begin bad++; $display("FAIL rst_burst_start got beats %0d want 3rd ack", beats); end
      wb_dat_i = d[2];
      rst = 1'b1;
      #1;
      total++; if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin bad++; $display("FAIL rst_burst_abort got ack %b dat %h want 0 0", wb_ack_o, wb_dat_o); end
      @(posedge clk); #1;
      rst = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_cti_i = 3'b000;
      model[200] = d[0];
      model[201] = d[1];
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         xfer(1'b0, BASE + 32'((200 + i) * 4), 2'b00, 1, 3'b000, 4'hF, -1, 0, done, gerr, lat, low, tail);
         total++; if (rd_buf[0] !== model[200 + i]) begin bad++; $display("FAIL rst_burst_mem word %0d got %h want %h", 200 + i, rd_buf[0], model[200 + i]); end
      end
   endtask

   task automatic test_cyc_abort();
      int done, lat, low, hits; logic gerr, tail;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = BASE + 32'(300 * 4);
      wb_cti_i = 3'b000; wb_sel_i = 4'hF; wb_dat_i = ~model[300];
      @(posedge clk); #1;
      hits = (wb_ack_o | wb_err_o) ? 1 : 0;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (wb_ack_o | wb_err_o) hits++;
      end
      total++; if (hits !== 0) begin bad++; $display("FAIL cyc_abort_ack got %0d want 0", hits); end
      xfer(1'b0, BASE + 32'(300 * 4), 2'b00, 1, 3'b000, 4'hF, -1, 0, done, gerr, lat, low, tail);
      total++; if (rd_buf[0] !== model[300]) begin bad++; $display("FAIL cyc_abort_mem got %h want %h", rd_buf[0], model[300]); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 40; it++) begin
         int start, n, sk, sl, exp_done, done, lat, low, w;
         logic we, gerr, tail;
         logic [1:0] bte;
         logic [3:0] sel;
         logic [2:0] cl;
         we    = 1'($urandom_range(0, 1));
         n     = $urandom_range(1, 8);
         bte   = 2'($urandom_range(0, 3));
         start = ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH - 8, DEPTH - 1)
                                             : $urandom_range(0, DEPTH - 1);
         sel   = we ? 4'($urandom_range(1, 15)) : 4'hF;
         case ($urandom_range(0, 4))
            0:       cl = 3'b000;
            1:       cl = 3'b001;
            2:       cl = 3'b011;
            3:       cl = 3'b100;
            default: cl = 3'b111;
         endcase
         if (n > 1) cl = 3'b111;
         sk = (n > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : -1;
         sl = $urandom_range(1, 3);
         for (int k = 0; k < n; k++) wd_buf[k] = $urandom;
         exp_done = (bte == 2'b00 && start + n > DEPTH) ? DEPTH - start : n;
         xfer(we, BASE + 32'(start * 4), bte, n, cl, sel, sk, sl, done, gerr, lat, low, tail);
         total++; if (done !== exp_done || gerr !== 1'(exp_done < n)) begin bad++; $display("FAIL rand_beats it %0d got %0d err %b want %0d", it, done, gerr, exp_done); end
         total++; if (lat !== WS + 2) begin bad++; $display("FAIL rand_latency it %0d got %0d want %0d", it, lat, WS + 2); end
         total++; if (tail !== 1'b0) begin bad++; $display("FAIL rand_tail it %0d got %b want 0", it, tail); end
         for (int k = 0; k < exp_done; k++) begin
            w = beat_word(start, bte, k);
            if (we) model[w] = merge(model[w], wd_buf[k], sel);
            else begin
               total++; if (rd_buf[k] !== model[w]) begin bad++; $display("FAIL rand_data it %0d beat %0d got %h want %h", it, k, rd_buf[k], model[w]); end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_classic_read();
      test_byte_write();
      test_wrap4();
      test_out_of_range();
      test_linear_overflow();
      test_stall();
      test_reset_mid_burst();
      test_cyc_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/or1k_wb_burst_ram.md
OR1K_WB_BURST_RAM -- requirements
Module: or1k_wb_burst_ram

Interface
REQ-001 SHALL have parameter MEM_DEPTH_WIDTH, default 10, meaning log2 of memory depth in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of word 0, aligned to memory size.
REQ-003 SHALL have parameter WAIT_STATES, default 1, range 0..7, meaning extra cycles before first ack of any transfer.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports wb_adr_i in 32, wb_dat_i in 32, wb_sel_i in 4, wb_we_i in 1, wb_cyc_i in 1, wb_stb_i in 1, wb_cti_i in 3, wb_bte_i in 2  Wishbone B3 slave inputs, driven by the OR1K iwbm_*/dwbm_* master.
REQ-007 SHALL have ports wb_dat_o out 32, wb_ack_o out 1, wb_err_o out 1, wb_rty_o out 1  Wishbone slave outputs, all registered.

Function
REQ-008 SHALL implement FSM states IDLE, WAIT, BURST, ERR.
REQ-009 SHALL, in IDLE, sample cyc_i&stb_i; out-of-range word address (adr_i-BASE_ADDR >= 4*2^MEM_DEPTH_WIDTH) -> ERR; else load wait counter with WAIT_STATES and go to WAIT (or directly to BURST-first-ack when WAIT_STATES=0).
REQ-010 SHALL assert first ack_o exactly WAIT_STATES+1 cycles after the edge where stb was sampled in IDLE.
REQ-011 SHALL treat cti_i 000, 001, 111 and reserved values as classic: single ack pulse, then IDLE; a new stb is sampled at the edge after ack drops.
REQ-012 SHALL treat cti_i==010 at first ack as burst: at each edge where ack_o=1 and cti_i==010, ack_o stays 1 next cycle with zero wait states for the next beat.
REQ-013 SHALL end a burst at the edge where ack_o=1 and cti_i==111; ack_o=0 next cycle, state IDLE.
REQ-014 SHALL generate next-beat word address internally per bte_i: 00 linear +1, 01 wrap-4, 10 wrap-8, 11 wrap-16 (low 2/3/4 address bits wrap, upper bits fixed).
REQ-015 SHALL, if stb_i=0 while cyc_i=1 in BURST, deassert ack_o, hold beat address, resume with ack on next cycle after stb_i returns.
REQ-016 SHALL, if cyc_i=0 in any non-IDLE state, return to IDLE next edge without ack/err and without committing writes.
REQ-017 SHALL, for a linear burst stepping beyond the last word, assert err_o for that beat instead of ack_o and go to IDLE.
REQ-018 SHALL commit writes only at the edge where ack_o=1, byte lane n written when sel_i[n]=1, lanes with sel=0 unchanged.
REQ-019 SHALL drive dat_o with the addressed word while ack_o=1 and 32'h0 otherwise.
REQ-020 SHALL pulse err_o for exactly one cycle from ERR, then IDLE; ack_o and err_o SHALL never both be 1.
REQ-021 SHALL tie rty_o to 0.

Reset
REQ-022 SHALL, on rst=1, asynchronously force state IDLE, ack_o=0, err_o=0, rty_o=0, dat_o=0, wait counter 0.
REQ-023 SHALL NOT clear memory contents on reset; rst mid-burst aborts with no further ack and no pending write.

Verification
REQ-024 Classic read, WAIT_STATES=1: mem[0x10]=32'hDEADBEEF, stb at adr 0x40 cti=000 -> ack one cycle, 2 cycles after sampling, dat_o=32'hDEADBEEF.
REQ-025 Write sel=4'b0101 dat=32'h11223344 to word holding 32'hAABBCCDD -> readback 32'hAA22CC44.
REQ-026 Wrap-4 read burst from adr 0x08 (words 2,3,0,1 = 2,3,0,1 data) cti=010x3 then 111 -> four consecutive ack cycles, data 2,3,0,1, ack low after last.
REQ-027 Access adr BASE_ADDR+0x1000 with MEM_DEPTH_WIDTH=10 -> err_o one cycle, ack_o never asserted, memory unchanged.
REQ-028 Linear burst: stb dropped 2 cycles after beat 1 -> ack low 2 cycles, beat 2 data correct on resume; rst asserted mid-burst -> ack_o=0 same cycle, IDLE, next classic read correct.
